mbscore_ifetch_ctrl: RTL and testbench
======================================

Name: mbscore_ifetch_ctrl

Overview:
Instruction-fetch sequencer for the MBScore core. It owns the fetch PC and issues single-outstanding requests to instruction memory. It buffers returned words with their PCs in a small prefetch FIFO and presents them to the core's `inst` input through a valid/ready handshake. It also handles branch/jump redirects from the core, flushing stale instructions and discarding in-flight responses.

Parameters:
DATA_WIDTH, 32, instruction word width (taken from the shared const file).
ADDR_WIDTH, 32, fetch address width.
FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  memory request; held until imem_ack.
imem_addr  output  ADDR_WIDTH  request address; stable while imem_req=1.
imem_ack  input  1  response valid; may arrive in the same cycle imem_req is first high.
imem_rdata  input  DATA_WIDTH  instruction word, valid when imem_ack=1.
redirect_valid  input  1  core requests a fetch from a new PC (1-cycle pulse).
redirect_pc  input  ADDR_WIDTH  target PC; bits [1:0] are ignored and forced to 0.
inst_valid  output  1  FIFO head valid.
inst  output  DATA_WIDTH  FIFO head word; 0 when inst_valid=0.
inst_pc  output  ADDR_WIDTH  PC of the head word; 0 when inst_valid=0.
inst_ready  input  1  core consumes the head when inst_valid & inst_ready.

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=RESET_PC, FIFO empty, state IDLE.
- FSM states:
  - IDLE: no request outstanding. Go to REQ when count < FIFO_DEPTH and there is no redirect this cycle. Drive imem_req=1 and imem_addr=fetch_pc (registered; visible the cycle after the decision).
  - REQ: request outstanding, waiting for imem_ack.
    - On ack without redirect: push {imem_rdata, imem_addr}, fetch_pc += 4.
    - Then, if the FIFO still has a free slot after this cycle's push/pop, issue the next request back-to-back (stay REQ, new address next cycle). Otherwise go to IDLE with imem_req=0.
  - DRAIN: a redirect arrived while a request was outstanding. Keep imem_req=1 and the old imem_addr until ack, then discard imem_rdata and go to IDLE.
- Redirect (redirect_valid=1), effective next edge:
  - Flush the FIFO (count=0, inst_valid=0 next cycle) and set fetch_pc = {redirect_pc[AW-1:2], 2'b00}.
  - In IDLE: stay IDLE and issue next cycle.
  - In REQ without ack: go to DRAIN.
  - In REQ with ack in the same cycle: discard the data and go to IDLE.
  - In DRAIN: update fetch_pc, stay DRAIN (or go to IDLE if ack arrives the same cycle).
  - A pop in the same cycle as a redirect is irrelevant; the flush wins.
- Latency:
  - Redirect at edge T → imem_req with the new PC visible after T+1.
  - With zero-wait ack, inst_valid=1 after T+2.
  - Sustained throughput is 1 instruction per cycle with zero-wait memory and inst_ready=1.
- FIFO:
  - First-word fall-through; inst and inst_pc are driven from the head.
  - Push and pop in the same cycle are both allowed, including at full (pop frees the slot).
  - A request is never issued unless a slot is guaranteed at ack time: count − pop + outstanding < FIFO_DEPTH.
  - Overflow is impossible by construction; a push when full is an assertion failure.
- Arithmetic:
  - fetch_pc increments by 4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap naturally.
- Invariants:
  - imem_addr never changes while imem_req=1 and no ack has been received.
  - A reset mid-request drops imem_req immediately (async).

Decomposition:
- Shared const file (MBScore_const.v) gains ADDR_WIDTH, INST_BYTES=4, RESET_PC default, and the FSM state encodings (IF_IDLE, IF_REQ, IF_DRAIN).
- One sub-module: mbscore_ifetch_fifo, a FWFT synchronous FIFO of {pc, inst} with push, pop, flush, count, empty and full.
- The controller instantiates it and adds the FSM and PC logic.

Test Plan:
1. Reset release, zero-wait ack, inst_ready=1 → imem_addr 0x0,0x4,0x8… on consecutive cycles; inst_valid high from cycle 2; inst_pc tracks 0x0,0x4,…; inst equals the memory word (e.g. 32'h00210820 at 0x0).
2. inst_ready=0, zero-wait ack → exactly 4 words buffered (PCs 0x0–0xC); imem_req drops; raising inst_ready drains in order and fetching resumes at 0x10.
3. Ack latency 3 cycles, redirect to 0x100 one cycle after the req at 0x8 → imem_addr stays 0x8 until ack; that word is never presented; next request 0x100; first inst_pc=0x100.
4. Redirect with redirect_pc=0x203 in the same cycle as an ack → data discarded, FIFO empty next cycle, next request address 0x200.
5. Redirect to 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
6. Assert rst_n=0 mid-REQ with 2 entries buffered → imem_req=0 and inst_valid=0 immediately; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/mbscore_ifetch_pkg.sv
// -----------------------------------------------------------------------------
// mbscore_ifetch_pkg
// Shared constants for the MBScore instruction-fetch slice: default data and
// address widths, instruction size in bytes, default reset PC and the fetch
// sequencer state encoding.
// -----------------------------------------------------------------------------
package mbscore_ifetch_pkg;

    localparam int          IF_DATA_WIDTH = 32;
    localparam int          IF_ADDR_WIDTH = 32;
    localparam int          IF_INST_BYTES = 4;
    localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,  // no request outstanding
        IF_REQ   = 2'd1,  // request outstanding, response will be kept
        IF_DRAIN = 2'd2   // request outstanding, response will be dropped
    } if_state_t;

endpackage : mbscore_ifetch_pkg

// File: rtl/mbscore_ifetch_fifo.sv
// -----------------------------------------------------------------------------
// mbscore_ifetch_fifo
// First-word fall-through synchronous FIFO holding {inst, pc} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry
//   pop        : consume the head (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   rdata      : head entry (contents undefined when empty)
//   count      : number of stored entries, 0..DEPTH
//   empty/full : status flags
// Push and pop in the same cycle are allowed when full (the pop frees a slot).
// -----------------------------------------------------------------------------
module mbscore_ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]    CNT_MAX = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define which
    // entries are meaningful, so resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The controller only requests when a slot is guaranteed, so a push
    // into a full FIFO without a matching pop means the slot logic is broken.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            a_no_overflow: assert (!(push && full && !pop))
                else $error("ifetch fifo overflow");
        end
    end

endmodule : mbscore_ifetch_fifo

// File: rtl/mbscore_ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// mbscore_ifetch_ctrl
// Instruction-fetch sequencer: owns the fetch PC, issues single-outstanding
// requests to instruction memory, buffers returned words in a prefetch FIFO
// and presents them to the core through a valid/ready handshake. Redirects
// flush the buffer and drop any response still in flight.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : memory request, address held until imem_ack
//   imem_ack/imem_rdata   : memory response (may come in the first req cycle)
//   redirect_valid/_pc    : new fetch target from the core (low 2 bits ignored)
//   inst_valid/inst/inst_pc/inst_ready : head of the prefetch buffer
// -----------------------------------------------------------------------------
module mbscore_ifetch_ctrl
    import mbscore_ifetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = IF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int             EW       = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW-1:0]  DEPTH_M1 = CW'(FIFO_DEPTH - 1);

    if_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         head;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_after_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  unused_pc_bits;

    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc[1:0];
    assign pc_plus4        = fetch_pc_q + ADDR_WIDTH'(IF_INST_BYTES);
    assign pop             = inst_valid && inst_ready;
    // pop is only ever set when count > 0, so this cannot underflow.
    assign count_after_pop = count - CW'(pop);

    mbscore_ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({imem_rdata, imem_addr}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // While in IF_REQ, fetch_pc_q always equals the outstanding address; it
    // advances on ack and becomes the next request address if one follows.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        case (state_q)
            IF_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end else if (!fifo_full) begin
                    state_d = IF_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            IF_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    state_d    = imem_ack ? IF_IDLE : IF_DRAIN;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus4;
                    // count + 1 - pop < DEPTH: a slot remains after this push.
                    if (count_after_pop < DEPTH_M1) begin
                        addr_d = pc_plus4;
                    end else begin
                        state_d = IF_IDLE;
                    end
                end
            end
            IF_DRAIN: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_ack) begin
                    state_d = IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    assign imem_req   = (state_q != IF_IDLE);
    assign imem_addr  = addr_q;
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? '0 : head[ADDR_WIDTH +: DATA_WIDTH];
    assign inst_pc    = fifo_empty ? '0 : head[ADDR_WIDTH-1:0];

endmodule : mbscore_ifetch_ctrl

// File: tb/tb_mbscore_ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mbscore_ifetch_ctrl
// Directed bench for the instruction-fetch sequencer. The memory model answers
// after a programmable number of wait cycles and returns 32'h00210820 + addr.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_mbscore_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int unsigned latency;
    int unsigned wait_cnt;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    mbscore_ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0021_0820 + addr;
    endfunction

    // Memory model: ack once the request has been held for `latency` cycles.
    assign imem_ack   = imem_req && (wait_cnt >= latency);
    assign imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req)             wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the falling edge where rst_n is released.
    task automatic do_reset(input int unsigned lat, input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = rdy;
        latency        = lat;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        latency        = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req",   imem_req,   32'h0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_valid", inst_valid, 32'h0);
        check("rst_inst",  inst,       32'h0);
        check("rst_pc",    inst_pc,    32'h0);

        // 1: zero-wait streaming with inst_ready=1
        @(negedge clk);
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        cyc(1);
        check("t1_req",   imem_req,   32'h1);
        check("t1_addr0", imem_addr,  32'h0);
        check("t1_valid0", inst_valid, 32'h0);
        cyc(1);
        check("t1_first_inst", inst, 32'h0021_0820);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1);
            check("t1_addr",  imem_addr,  32'(4 * (i + 1)));
            check("t1_valid", inst_valid, 32'h1);
            check("t1_pc",    inst_pc,    32'(4 * i));
            check("t1_inst",  inst,       mem_word(32'(4 * i)));
        end

        // 2: back-pressure fills the buffer, then drains in order
        do_reset(0, 1'b0);
        cyc(5);
        check("t2_req_off", imem_req,   32'h0);
        check("t2_valid",   inst_valid, 32'h1);
        check("t2_pc0",     inst_pc,    32'h0);
        cyc(1);
        check("t2_stall_req", imem_req, 32'h0);
        check("t2_stall_pc",  inst_pc,  32'h0);
        inst_ready = 1'b1;
        cyc(1);
        check("t2_pc4",   inst_pc,  32'h4);
        check("t2_idle",  imem_req, 32'h0);
        cyc(1);
        check("t2_pc8",     inst_pc,   32'h8);
        check("t2_resume",  imem_req,  32'h1);
        check("t2_addr10",  imem_addr, 32'h10);
        cyc(1);
        check("t2_pcC",   inst_pc,   32'hC);
        check("t2_addr14", imem_addr, 32'h14);
        cyc(1);
        check("t2_pc10",   inst_pc, 32'h10);
        check("t2_inst10", inst,    32'h0021_0830);

        // 3: slow memory, redirect while the request at 0x8 is outstanding
        do_reset(3, 1'b1);
        cyc(9);
        check("t3_addr8", imem_addr, 32'h8);
        check("t3_pc4",   inst_pc,   32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc(1);
        redirect_valid = 1'b0;
        check("t3_flush", inst_valid, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc(1);
            check("t3_drain_req",  imem_req,  32'h1);
            check("t3_drain_addr", imem_addr, 32'h8);
        end
        cyc(1);
        check("t3_idle_req",   imem_req,   32'h0);
        check("t3_idle_valid", inst_valid, 32'h0);
        cyc(1);
        check("t3_new_req",  imem_req,  32'h1);
        check("t3_new_addr", imem_addr, 32'h100);
        cyc(3);
        check("t3_wait_valid", inst_valid, 32'h0);
        cyc(1);
        check("t3_valid", inst_valid, 32'h1);
        check("t3_pc",    inst_pc,    32'h100);
        check("t3_inst",  inst,       32'h0021_0920);

        // 4: redirect with a misaligned target in the same cycle as an ack
        do_reset(0, 1'b0);
        cyc(2);
        check("t4_pre_addr",  imem_addr,  32'h4);
        check("t4_pre_valid", inst_valid, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        cyc(1);
        redirect_valid = 1'b0;
        check("t4_flush", inst_valid, 32'h0);
        check("t4_idle",  imem_req,   32'h0);
        cyc(1);
        check("t4_req",  imem_req,  32'h1);
        check("t4_addr", imem_addr, 32'h200);
        cyc(1);
        check("t4_pc",   inst_pc, 32'h200);
        check("t4_inst", inst,    32'h0021_0A20);

        // 5: PC wrap at the top of the address space
        do_reset(0, 1'b1);
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc(1);
        redirect_valid = 1'b0;
        check("t5_idle", imem_req, 32'h0);
        cyc(1);
        check("t5_addr_f8", imem_addr, 32'hFFFF_FFF8);
        cyc(1);
        check("t5_addr_fc", imem_addr, 32'hFFFF_FFFC);
        check("t5_pc_f8",   inst_pc,   32'hFFFF_FFF8);
        check("t5_inst_f8", inst,      32'h0021_0818);
        cyc(1);
        check("t5_addr_0", imem_addr, 32'h0);
        check("t5_pc_fc",  inst_pc,   32'hFFFF_FFFC);
        cyc(1);
        check("t5_pc_0",   inst_pc,   32'h0);
        check("t5_addr_4", imem_addr, 32'h4);

        // 6: asynchronous reset in the middle of a request
        do_reset(0, 1'b0);
        cyc(3);
        check("t6_pre_req",   imem_req,   32'h1);
        check("t6_pre_valid", inst_valid, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_req",   imem_req,   32'h0);
        check("t6_valid", inst_valid, 32'h0);
        check("t6_pc",    inst_pc,    32'h0);
        check("t6_addr",  imem_addr,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("t6_restart_req",  imem_req,  32'h1);
        check("t6_restart_addr", imem_addr, 32'h0);
        cyc(1);
        check("t6_restart_pc", inst_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mbscore_ifetch_ctrl
